// File: rtl/rpm_seq_multiplier.sv
// rpm_seq_multiplier
//   Iterative Russian-peasant (shift-and-add) multiplier. Each RUN cycle
//   looks at the LSB of the halving multiplier x. When that bit is set, the
//   doubling multiplicand y is added into the accumulator. Iteration stops
//   as soon as no set bits remain in x, so N = max(1, bit length of |a|).
//   Signed mode works on magnitudes and applies the sign to the final
//   product.
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    operation request, sampled only in IDLE
//   sgn      1 = two's-complement operands, sampled with start
//   a        multiplier (halved each iteration), sampled with start
//   b        multiplicand (doubled each iteration), sampled with start
//   busy     high in RUN and DONE
//   done     one-cycle pulse, product valid
//   product  2*WIDTH-bit result, held until the next completion
module rpm_seq_multiplier #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               sgn,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [WIDTH-1:0]   x;
   logic [2*WIDTH-1:0] y;
   logic [2*WIDTH-1:0] acc;
   logic               neg;

   logic [2*WIDTH-1:0] addend;
   logic [2*WIDTH-1:0] sum;
   logic               last;

   // Magnitude in WIDTH unsigned bits. The most negative value maps onto
   // 2^(WIDTH-1), which still fits because the result is unsigned.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                  input logic             s);
      logic signed [WIDTH-1:0] sv;
      sv = v;
      if (s && sv < 0)
         magnitude = -sv;
      else
         magnitude = v;
   endfunction

   // Applies the latched sign to the unsigned magnitude product.
   function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] m,
                                                     input logic               n);
      logic signed [2*WIDTH-1:0] sm;
      sm = m;
      apply_sign = n ? -sm : sm;
   endfunction

   assign addend = x[0] ? y : '0;
   assign sum    = acc + addend;
   // The final iteration is the one that leaves no set bits in x.
   assign last   = ((x >> 1) == '0);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_RUN;
         S_RUN:   if (last)  state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs decode from the state register only, so done is never
   // combinational from the inputs.
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         S_RUN:   busy = 1'b1;
         S_DONE:  begin busy = 1'b1; done = 1'b1; end
         default: ;
      endcase
   end

   // Datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x       <= '0;
         y       <= '0;
         acc     <= '0;
         neg     <= 1'b0;
         product <= '0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               x   <= magnitude(a, sgn);
               y   <= {{WIDTH{1'b0}}, magnitude(b, sgn)};
               acc <= '0;
               neg <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            end
            S_RUN: begin
               acc <= sum;
               x   <= x >> 1;
               y   <= y << 1;
               if (last)
                  product <= apply_sign(sum, neg);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rpm_seq_multiplier.sv
module tb_rpm_seq_multiplier;

   localparam int W = 32;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           start;
   logic           sgn;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           busy;
   logic           done;
   logic [2*W-1:0] product;

   int n_tests = 0;
   int n_fail  = 0;

   rpm_seq_multiplier #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .sgn     (sgn),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: product from plain integer multiplication of the operands.
   function automatic logic [63:0] ref_product(input logic s, input logic [W-1:0] ra,
                                               input logic [W-1:0] rb);
      logic signed [63:0] sa, sb;
      if (s) begin
         sa = {{W{ra[W-1]}}, ra};
         sb = {{W{rb[W-1]}}, rb};
         return sa * sb;
      end
      return {32'b0, ra} * {32'b0, rb};
   endfunction

   // Reference: iteration count = bit length of |a|, at least 1.
   function automatic int ref_iters(input logic s, input logic [W-1:0] ra);
      longint m;
      int     n;
      m = (s && ra[W-1]) ? (longint'(64'h1_0000_0000) - longint'({32'b0, ra}))
                         : longint'({32'b0, ra});
      n = 0;
      while (m != 0) begin
         n++;
         m = m >> 1;
      end
      return (n == 0) ? 1 : n;
   endfunction

   // One operation: start at edge T, then count edges until done.
   // When spam is set, start is held high with other operands all the time
   // the block is busy; those requests must be ignored.
   task automatic run_op(input logic s, input logic [W-1:0] ra, input logic [W-1:0] rb,
                         input bit spam, input string tag);
      logic [63:0] prev, exp;
      int          n, cyc;
      bit          seen;
      exp  = ref_product(s, ra, rb);
      n    = ref_iters(s, ra);
      prev = product;
      start = 1'b1; sgn = s; a = ra; b = rb;
      @(posedge clk); #1;
      chk({tag, ".busy_after_start"}, {63'b0, busy}, 64'd1);
      if (spam) begin
         sgn = $urandom_range(1); a = $urandom; b = $urandom;
      end else begin
         start = 1'b0;
      end
      cyc  = 0;
      seen = 0;
      while (!seen && cyc < W + 4) begin
         if (cyc == 0) chk({tag, ".product_held"}, product, prev);
         @(posedge clk); #1;
         cyc++;
         if (done) seen = 1;
         else if (spam) begin
            sgn = $urandom_range(1); a = $urandom; b = $urandom;
         end
      end
      if (!seen) begin
         chk({tag, ".done_timeout"}, 64'd0, 64'd1);
         start = 1'b0;
         return;
      end
      chk({tag, ".latency"}, 64'(cyc), 64'(n));
      chk({tag, ".product"}, product, exp);
      @(posedge clk); #1;
      start = 1'b0;
      chk({tag, ".done_fall"}, {62'b0, done, busy}, 64'd0);
      chk({tag, ".product_keep"}, product, exp);
      @(posedge clk); #1;
      chk({tag, ".idle"}, {63'b0, busy}, 64'd0);
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      rst_n = 1'b0; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
      #1;
      chk("reset.state", {product, 62'b0, busy, done} == '0 ? 64'd0 : 64'd1, 64'd0);
      chk("reset.product", product, 64'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(1'b0, 32'd13, 32'd11, 0, "u13x11");
      run_op(1'b0, 32'd0, 32'hDEADBEEF, 0, "u0");
      run_op(1'b0, 32'd1, 32'hDEADBEEF, 0, "u1");
      run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, "umax");
      run_op(1'b1, 32'hFFFFFFFD, 32'd5, 0, "sm3x5");
      run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 0, "sminxm1");
      run_op(1'b0, 32'd13, 32'd11, 1, "spam_u");
      run_op(1'b1, 32'h0000F00D, 32'h80000000, 1, "spam_s");

      for (int i = 0; i < 25; i++) begin
         ra = $urandom >> $urandom_range(31);
         rb = $urandom;
         run_op(1'($urandom_range(1)), ra, rb, bit'($urandom_range(1)), "rand");
      end

      // Reset mid-operation.
      start = 1'b1; sgn = 1'b0; a = 32'hFFFFFFFF; b = 32'd2;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("abort.busy_done", {62'b0, busy, done}, 64'd0);
      chk("abort.product", product, 64'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      begin
         bit any_done = 0;
         repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) any_done = 1;
         end
         chk("abort.no_done", {63'b0, any_done}, 64'd0);
      end
      run_op(1'b0, 32'd6, 32'd7, 0, "after_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
